// File: rtl/top_acc_pkg.sv
// Shared types and width constants for the accumulate/requantise stage.
package top_acc_pkg;

    localparam int IN_W  = 32;
    localparam int ACC_W = 48;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;

    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/top_acc_round_sat.sv
// Combinational requantiser: round-half-up arithmetic right shift of the group
// sum, then signed saturation to OUT_W bits.
// Optional macro TOP_ACC_RELU_EN: clamp negative results to zero; the overflow
// flag then reports positive saturation only.
module top_acc_round_sat
    import top_acc_pkg::*;
(
    input  logic [ACC_W-1:0] sum,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] res,
    output logic             ovf
);

    localparam logic signed [ACC_W:0] MAX_X = (ACC_W + 1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] MIN_X = (ACC_W + 1)'(OUT_MIN);

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One extra bit of headroom so adding the rounding bias can never wrap.
    always_comb begin
        ext     = {sum[ACC_W-1], sum};
        bias    = '0;
        if (shift != 5'd0) begin
            bias = (ACC_W + 1)'(1) << (shift - 5'd1);
        end
        biased  = ext + bias;
        shifted = biased >>> shift;
    end

    // Saturate to the output range, then apply the optional ReLU clamp.
    always_comb begin
        res = shifted[OUT_W-1:0];
        ovf = 1'b0;
        if (shifted > MAX_X) begin
            res = OUT_W'(OUT_MAX);
            ovf = 1'b1;
        end else if (shifted < MIN_X) begin
            res = OUT_W'(OUT_MIN);
            ovf = 1'b1;
        end
`ifdef TOP_ACC_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
            ovf = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/top_acc_requant.sv
// Group accumulator with single-step requantisation and a one-deep output
// register on a valid/ready handshake.
// Optional macro TOP_ACC_RELU_EN (handled in top_acc_round_sat).
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | no result held; beats accumulate
// HOLD  | result held in output register; out_valid = 1
module top_acc_requant
    import top_acc_pkg::*;
(
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       cfg_shift,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             retire;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;
    logic [OUT_W-1:0] rs_res;
    logic             rs_ovf;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;
    assign sum       = acc_q + {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    assign out_data  = data_q;
    assign out_cnt   = ocnt_q;
    assign out_ovf   = ovf_q;

    top_acc_round_sat u_round_sat (
        .sum   (sum),
        .shift (cfg_shift),
        .res   (rs_res),
        .ovf   (rs_ovf)
    );

    // Next-state: accumulate, load a result on the last beat, or retire.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ocnt_d  = ocnt_q;
        ovf_d   = ovf_q;
        if (accept && in_last) begin
            // A last beat may land in the same cycle the held result retires.
            acc_d   = '0;
            cnt_d   = '0;
            data_d  = rs_res;
            ovf_d   = rs_ovf;
            ocnt_d  = cnt_inc;
            state_d = HOLD;
        end else begin
            if (accept) begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
            if (retire) begin
                state_d = ACC;
            end
        end
    end

    // State and datapath registers; outputs clear immediately on reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ocnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ocnt_q  <= ocnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
